// File: rtl/router_1xn.sv
// router_1xn: 1-to-N packet router with per-channel FIFOs, parity check and idle-channel flush
// Parameters: NUM_PORTS channels (2..8), DATA_W byte width, FIFO_DEPTH entries per channel (power of 2),
//   TIMEOUT unread cycles before a non-empty channel is flushed.
// Ports: clk, rst (synchronous, active-high); d_in/pkt_valid byte stream; rd_en per-channel pop;
//   vld_out channel non-empty; dout channel i at [i*DATA_W +: DATA_W]; busy byte not accepted;
//   err parity-error pulse (CHECK cycle); drop bad-address pulse; err_cnt parity-error count.
// Build option: define ROUTER_ERR_CNT_EN for a saturating err_cnt; otherwise err_cnt is tied to 0.
module router_1xn #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           d_in,
  input  logic                        pkt_valid,
  input  logic [NUM_PORTS-1:0]        rd_en,
  output logic [NUM_PORTS-1:0]        vld_out,
  output logic [NUM_PORTS*DATA_W-1:0] dout,
  output logic                        busy,
  output logic                        err,
  output logic                        drop,
  output logic [7:0]                  err_cnt
);
  localparam int A  = $clog2(NUM_PORTS);
  localparam int LW = DATA_W - A;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, PARITY, CHECK, DROP} state_t;
  state_t state, state_n;
  logic [A-1:0] dest, dest_n, tgt;
  logic [LW-1:0] len, len_n;
  logic [DATA_W-1:0] par, par_n;
  logic drop_n, hdr_ok, wr_state, kill, acc;
  logic [NUM_PORTS-1:0] full, flush, we;
  // Padded to 2**A so a decoded address can index them without range checks
  logic [(1<<A)-1:0] full_x, flush_x;
  always_comb begin
    full_x = '0;
    flush_x = '0;
    full_x[NUM_PORTS-1:0] = full;
    flush_x[NUM_PORTS-1:0] = flush;
  end
  assign hdr_ok   = int'(d_in[A-1:0]) < NUM_PORTS;
  assign tgt      = state == IDLE ? d_in[A-1:0] : dest;
  assign wr_state = (state == IDLE && hdr_ok) || state == LOAD || state == PARITY;
  assign busy     = state == CHECK || (wr_state && full_x[tgt]);
  assign acc      = pkt_valid && !busy;
  // Destination FIFO is being flushed this edge: the rest of the packet is discarded
  assign kill     = wr_state && flush_x[tgt];
  assign err      = state == CHECK && |par;
  always_comb begin
    state_n = state;
    dest_n = dest;
    len_n = len;
    par_n = par;
    drop_n = 1'b0;
    case (state)
      IDLE: if (acc) begin
        dest_n = d_in[A-1:0];
        len_n = d_in[DATA_W-1:A];
        par_n = d_in;
        drop_n = !hdr_ok;
        state_n = !hdr_ok || kill ? DROP : d_in[DATA_W-1:A] == '0 ? PARITY : LOAD;
      end
      LOAD: if (kill) begin
        len_n = acc ? len - LW'(1) : len;
        state_n = DROP;
      end else if (acc) begin
        len_n = len - LW'(1);
        par_n = par ^ d_in;
        state_n = len == LW'(1) ? PARITY : LOAD;
      end
      PARITY: if (kill) begin
        len_n = '0;
        state_n = acc ? IDLE : DROP;
      end else if (acc) begin
        par_n = par ^ d_in;
        state_n = CHECK;
      end
      CHECK: state_n = IDLE;
      DROP: if (acc) begin
        len_n = len - LW'(1);
        state_n = len == '0 ? IDLE : DROP;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dest <= '0;
      len <= '0;
      par <= '0;
      drop <= 1'b0;
    end else begin
      state <= state_n;
      dest <= dest_n;
      len <= len_n;
      par <= par_n;
      drop <= drop_n;
    end
  end
  for (genvar g = 0; g < NUM_PORTS; g++) begin : ch
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [DATA_W-1:0] q;
    logic [PW-1:0] wp, rp;
    logic [PW:0] cnt;
    logic [TW-1:0] tc;
    logic re;
    assign we[g] = acc && wr_state && !kill && tgt == A'(g);
    assign re = rd_en[g] && vld_out[g];
    assign vld_out[g] = |cnt;
    assign full[g] = cnt == (PW+1)'(FIFO_DEPTH);
    assign flush[g] = vld_out[g] && !rd_en[g] && tc == TW'(TIMEOUT - 1);
    assign dout[g*DATA_W +: DATA_W] = q;
    always_ff @(posedge clk) if (we[g]) mem[wp] <= d_in;
    always_ff @(posedge clk) begin
      if (rst) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        tc <= '0;
        q <= '0;
      end else if (flush[g]) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        tc <= '0;
      end else begin
        wp <= wp + PW'(we[g]);
        rp <= rp + PW'(re);
        cnt <= cnt + (PW+1)'(we[g]) - (PW+1)'(re);
        tc <= vld_out[g] && !rd_en[g] ? tc + TW'(1) : '0;
        if (re) q <= mem[rp];
      end
    end
  end
`ifdef ROUTER_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) err_cnt <= '0;
    else if (err && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_router_1xn.sv
// tb_router_1xn: directed scoreboard bench for router_1xn with three channels
module tb_router_1xn;
  localparam int NP = 3;
  localparam int TO = 30;
`ifdef ROUTER_ERR_CNT_EN
  localparam logic [7:0] EC = 8'd1;
`else
  localparam logic [7:0] EC = 8'd0;
`endif
  logic clk, rst, pkt_valid, busy, err, drop, a;
  logic [7:0] d_in, err_cnt, p;
  logic [NP-1:0] rd_en, vld_out;
  logic [NP*8-1:0] dout;
  logic [7:0] q [NP][$];
  int vec, miss, t0;
  int cyc = 0;

  router_1xn #(.NUM_PORTS(NP), .DATA_W(8), .FIFO_DEPTH(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .pkt_valid(pkt_valid), .rd_en(rd_en),
    .vld_out(vld_out), .dout(dout), .busy(busy), .err(err), .drop(drop), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int dst, output logic acc);
    logic [NP-1:0] r;
    logic [7:0] e;
    #1;
    r = rd_en & vld_out;
    acc = pkt_valid && !busy && !rst;
    @(posedge clk);
    #1;
    if (acc && dst >= 0) q[dst].push_back(d_in);
    for (int i = 0; i < NP; i++) begin
      if (r[i]) begin
        if (q[i].size() == 0) chk($sformatf("spurious_vld%0d", i), 32'(r[i]), 0);
        else begin
          e = q[i].pop_front();
          chk($sformatf("dout%0d", i), 32'(dout[i*8 +: 8]), 32'(e));
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input int dst);
    logic ok = 1'b0;
    int n = 0;
    d_in = b;
    pkt_valid = 1'b1;
    while (!ok && n < 100) begin
      tick(dst, ok);
      n++;
    end
    chk("accept", 32'(ok), 1);
  endtask

  task automatic drain(input int ch);
    logic dummy;
    int n = 0;
    rd_en[ch] = 1'b1;
    while (q[ch].size() > 0 && n < 64) begin
      tick(-1, dummy);
      n++;
    end
    rd_en[ch] = 1'b0;
    chk($sformatf("left%0d", ch), q[ch].size(), 0);
    chk($sformatf("empty%0d", ch), 32'(vld_out[ch]), 0);
  endtask

  initial begin
    vec = 0;
    miss = 0;
    rst = 1'b1;
    pkt_valid = 1'b0;
    d_in = '0;
    rd_en = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_vld", 32'(vld_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_drop", 32'(drop), 0);
    chk("rst_errcnt", 32'(err_cnt), 0);
    chk("rst_dout", 32'(dout), 0);
    send(8'h0D, 1); send(8'h11, 1); send(8'h22, 1); send(8'h33, 1); send(8'h0D, 1);
    pkt_valid = 1'b0;
    chk("good_err", 32'(err), 0);
    chk("good_check_busy", 32'(busy), 1);
    chk("good_vld", 32'(vld_out), 32'b010);
    chk("good_depth", q[1].size(), 5);
    drain(1);
    send(8'h0D, 1); send(8'h11, 1); send(8'h22, 1); send(8'h33, 1); send(8'h28, 1);
    pkt_valid = 1'b0;
    chk("bad_err_on", 32'(err), 1);
    tick(-1, a);
    chk("bad_err_off", 32'(err), 0);
    chk("bad_errcnt", 32'(err_cnt), 32'(EC));
    drain(1);
    send(8'h00, 0);
    t0 = cyc;
    send(8'h00, 0); send(8'h06, 2); send(8'hAB, 2); send(8'hAD, 2);
    pkt_valid = 1'b0;
    chk("b2b_cycles", cyc - t0, 5);
    chk("b2b_vld", 32'(vld_out), 32'b101);
    drain(0);
    drain(2);
    send(8'h0B, -1);
    chk("drop_on", 32'(drop), 1);
    chk("drop_vld", 32'(vld_out), 0);
    send(8'h01, -1);
    chk("drop_off", 32'(drop), 0);
    send(8'h02, -1); send(8'h03, -1);
    pkt_valid = 1'b0;
    chk("drop_vld_after", 32'(vld_out), 0);
    send(8'h0A, 2); send(8'h5A, 2); send(8'hA5, 2); send(8'hF5, 2);
    pkt_valid = 1'b0;
    chk("after_drop_err", 32'(err), 0);
    chk("after_drop_vld", 32'(vld_out), 32'b100);
    drain(2);
    send(8'h06, 2); send(8'h77, 2); send(8'h71, 2);
    pkt_valid = 1'b0;
    rd_en[2] = 1'b1;
    tick(-1, a);
    rd_en[2] = 1'b0;
    repeat (TO - 1) tick(-1, a);
    chk("timeout_not_yet", 32'(vld_out[2]), 1);
    tick(-1, a);
    chk("timeout_flushed", 32'(vld_out[2]), 0);
    q[2].delete();
    send(8'h50, 0);
    p = 8'h50;
    for (int i = 1; i <= 15; i++) begin
      send(8'(i * 7), 0);
      p ^= 8'(i * 7);
    end
    d_in = 8'(16 * 7);
    #1;
    chk("full_busy", 32'(busy), 1);
    chk("full_vld", 32'(vld_out), 1);
    rd_en[0] = 1'b1;
    tick(0, a);
    rd_en[0] = 1'b0;
    chk("full_blocked", 32'(a), 0);
    chk("full_busy_freed", 32'(busy), 0);
    tick(0, a);
    p ^= 8'(16 * 7);
    chk("full_one_accepted", 32'(a), 1);
    chk("full_busy_again", 32'(busy), 1);
    rd_en[0] = 1'b1;
    for (int i = 17; i <= 20; i++) begin
      send(8'(i * 7), 0);
      p ^= 8'(i * 7);
    end
    send(p, 0);
    pkt_valid = 1'b0;
    chk("long_err", 32'(err), 0);
    drain(0);
    send(8'h15, 1); send(8'h01, 1); send(8'h02, 1);
    pkt_valid = 1'b0;
    rst = 1'b1;
    tick(-1, a);
    rst = 1'b0;
    q[1].delete();
    chk("midrst_vld", 32'(vld_out), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_dout", 32'(dout), 0);
    send(8'h04, 0); send(8'h3C, 0); send(8'h38, 0);
    pkt_valid = 1'b0;
    chk("midrst_err", 32'(err), 0);
    chk("midrst_vld0", 32'(vld_out), 1);
    drain(0);
    chk("final_errcnt", 32'(err_cnt), 32'(EC));
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
